// File: rtl/arb_client.sv
// Requester-side front end for a round-robin arbiter: buffers words, requests the bus,
// drains bounded bursts on grant. Optional watchdog enabled by ARB_CLIENT_TIMEOUT_EN.
module arb_client #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          req,
  input  logic                          gnt,
  output logic                          bus_valid,
  output logic [DATA_W-1:0]             bus_data,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          timeout_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_REL} state_t;

  state_t              state_reg, state_next;
  logic                req_reg, req_next;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]       level_reg;
  logic [BW-1:0]       beat_reg;
  logic                bus_valid_reg;
  logic [DATA_W-1:0]   bus_data_reg;
  logic                wr_en, pop, beat_last, timeout_hit;

  assign wr_ready  = (level_reg != LW'(FIFO_DEPTH));
  assign wr_en     = wr_valid & wr_ready;
  assign pop       = (state_reg == S_XFER) & gnt & (level_reg != '0);
  assign beat_last = (beat_reg == BW'(BURST_LEN - 1));

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // The registered read port doubles as the bus output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_valid_reg <= 1'b0;
      bus_data_reg  <= '0;
    end else begin
      bus_valid_reg <= pop;
      if (pop)
        bus_data_reg <= mem[rd_ptr_reg];
    end
  end

  // Held at zero outside XFER, so it is clear on every entry to XFER.
  always_ff @(posedge clk) begin
    if (rst || state_reg != S_XFER)
      beat_reg <= '0;
    else if (pop)
      beat_reg <= beat_reg + 1'b1;
  end

`ifdef ARB_CLIENT_TIMEOUT_EN
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [WW-1:0] wait_reg;

  always_ff @(posedge clk) begin
    if (rst || state_reg != S_REQ)
      wait_reg <= '0;
    else if (!gnt)
      wait_reg <= wait_reg + 1'b1;
  end

  assign timeout_hit = (state_reg == S_REQ) & ~gnt & (wait_reg == WW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      req_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (level_reg != '0) state_next = S_REQ;
      S_REQ: begin
        if (gnt)
          state_next = S_XFER;
        else if (timeout_hit)
          state_next = S_REL;
      end
      // Without a pop the grant was lost or the FIFO ran dry.
      S_XFER: if (!pop || beat_last) state_next = S_REL;
      S_REL:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_next    = (state_next == S_REQ) || (state_next == S_XFER);
    timeout_err = timeout_hit;
  end

  assign req       = req_reg;
  assign bus_valid = bus_valid_reg;
  assign bus_data  = bus_data_reg;
  assign level     = level_reg;

endmodule
